// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_scheduler
//  Purpose  : Time-multiplexed scan of an 8-digit seven-segment display.
//             Each digit gets an ON_CYCLES lit slot, followed by a
//             BLANK_CYCLES gap with every digit off. The displayed value is a
//             persistent CPU value, or a debug overlay that is shown for
//             HOLD_FRAMES frames. The shown value only changes at frame
//             boundaries (digit 7 -> 0), so a frame never tears.
//  Ports    : clk, rst                      clock, sync active-high reset
//             i_cpu_wr_en, i_cpu_wr_data    persistent value write strobe/data
//             i_dbg_req, i_dbg_data         overlay request (held until ack)
//             o_dbg_ack                     1-cycle overlay acknowledge
//             o_digit_sel                   index of the current digit
//             o_digit                       nibble for o_digit_sel (comb.)
//             o_seg_en                      one-hot digit enable, 0 in blank
//             o_frame_start                 pulse at the start of digit 0
//             o_overlay_active              overlay owns the display
//  Options  : SEG_LZ_BLANK_EN - suppress leading-zero digits (digit 0 always lit)
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_scheduler #(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HOLD_FRAMES  = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cpu_wr_en,
    input  logic [31:0] i_cpu_wr_data,
    input  logic        i_dbg_req,
    input  logic [31:0] i_dbg_data,
    output logic        o_dbg_ack,
    output logic [2:0]  o_digit_sel,
    output logic [3:0]  o_digit,
    output logic [7:0]  o_seg_en,
    output logic        o_frame_start,
    output logic        o_overlay_active
);

    localparam int c_CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_HOLD_W  = $clog2(HOLD_FRAMES + 1);

    localparam logic               c_HAS_BLANK  = (BLANK_CYCLES != 0);
    localparam logic [c_CNT_W-1:0] c_ON_LAST    = c_CNT_W'(ON_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_FRAMES);

    localparam logic [0:0] c_ST_SCAN  = 1'b0;
    localparam logic [0:0] c_ST_BLANK = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_digit_sel;
    logic [31:0]         r_shown_val;
    logic [31:0]         r_cpu_val;
    logic [31:0]         r_dbg_val;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_dbg_ack;
    logic                r_frame_start;
    logic                r_overlay_active;

    logic                w_on_done;
    logic                w_blank_done;
    logic                w_advance;
    logic                w_frame_edge;
    logic                w_capture;
    logic                w_lz_hide;
    logic [7:0]          w_seg_en;

    assign w_on_done    = (r_state == c_ST_SCAN)  && (r_cnt == c_ON_LAST);
    assign w_blank_done = (r_state == c_ST_BLANK) && (r_cnt == c_BLANK_LAST);
    // Without a blank phase the digit advances straight out of SCAN.
    assign w_advance    = c_HAS_BLANK ? w_blank_done : w_on_done;
    assign w_frame_edge = w_advance && (r_digit_sel == 3'd7);
    // Ack is never high two cycles running; a held request re-acks every other cycle.
    assign w_capture    = i_dbg_req && !r_dbg_ack;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_SCAN:  if (w_on_done && c_HAS_BLANK) w_state_nxt = c_ST_BLANK;
            c_ST_BLANK: if (w_blank_done)             w_state_nxt = c_ST_SCAN;
            default:    w_state_nxt = c_ST_SCAN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
`ifdef SEG_LZ_BLANK_EN
    logic [2:0] w_msd;
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_shown_val[4*i +: 4] != 4'd0) w_msd = 3'(i);
        end
    end
    assign w_lz_hide = (r_digit_sel > w_msd);
`else
    assign w_lz_hide = 1'b0;
`endif

    always_comb begin
        w_seg_en = 8'd0;
        if (r_state == c_ST_SCAN && !w_lz_hide) w_seg_en = 8'b1 << r_digit_sel;
    end

    // ---------------- slot timing ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_digit_sel <= 3'd0;
        end else begin
            if (w_on_done || w_blank_done) r_cnt <= '0;
            else                           r_cnt <= r_cnt + 1'b1;
            if (w_advance) r_digit_sel <= r_digit_sel + 3'd1;
        end
    end

    // ---------------- value ownership ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shown_val      <= 32'd0;
            r_cpu_val        <= 32'd0;
            r_dbg_val        <= 32'd0;
            r_hold_cnt       <= '0;
            r_dbg_ack        <= 1'b0;
            r_frame_start    <= 1'b0;
            r_overlay_active <= 1'b0;
        end else begin
            r_dbg_ack     <= w_capture;
            r_frame_start <= w_frame_edge;
            if (i_cpu_wr_en) r_cpu_val <= i_cpu_wr_data;

            // Boundary decisions use pre-edge values.
            if (w_frame_edge) begin
                if (!r_overlay_active) begin
                    r_shown_val <= r_cpu_val;
                end else if (r_hold_cnt != '0) begin
                    r_shown_val <= r_dbg_val;
                    r_hold_cnt  <= r_hold_cnt - 1'b1;
                end else begin
                    r_overlay_active <= 1'b0;
                    r_shown_val      <= r_cpu_val;
                end
            end

            // A capture overrides the boundary update of the overlay state.
            if (w_capture) begin
                r_dbg_val        <= i_dbg_data;
                r_hold_cnt       <= c_HOLD_LOAD;
                r_overlay_active <= 1'b1;
            end
        end
    end

    assign o_dbg_ack        = r_dbg_ack;
    assign o_digit_sel      = r_digit_sel;
    assign o_digit          = r_shown_val[{r_digit_sel, 2'b00} +: 4];
    assign o_seg_en         = w_seg_en;
    assign o_frame_start    = r_frame_start;
    assign o_overlay_active = r_overlay_active;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_scheduler
//  Purpose  : Directed self-checking bench for seg_scan_scheduler with
//             ON_CYCLES=4, BLANK_CYCLES=1, HOLD_FRAMES=2 (40-cycle frame).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_scheduler;

    logic        clk;
    logic        rst;
    logic        i_cpu_wr_en;
    logic [31:0] i_cpu_wr_data;
    logic        i_dbg_req;
    logic [31:0] i_dbg_data;
    logic        o_dbg_ack;
    logic [2:0]  o_digit_sel;
    logic [3:0]  o_digit;
    logic [7:0]  o_seg_en;
    logic        o_frame_start;
    logic        o_overlay_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg_scan_scheduler #(
        .ON_CYCLES    (4),
        .BLANK_CYCLES (1),
        .HOLD_FRAMES  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cpu_wr_en      (i_cpu_wr_en),
        .i_cpu_wr_data    (i_cpu_wr_data),
        .i_dbg_req        (i_dbg_req),
        .i_dbg_data       (i_dbg_data),
        .o_dbg_ack        (o_dbg_ack),
        .o_digit_sel      (o_digit_sel),
        .o_digit          (o_digit),
        .o_seg_en         (o_seg_en),
        .o_frame_start    (o_frame_start),
        .o_overlay_active (o_overlay_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected scan position, cyc = cycles since the reset edge.
    function automatic logic [2:0] exp_sel(int c);
        return 3'((c / 5) % 8);
    endfunction

    function automatic logic [7:0] exp_seg(int c, logic [31:0] v);
        logic [2:0] s;
        logic [2:0] msd;
        s   = exp_sel(c);
        msd = 3'd0;
        if (c % 5 == 4) return 8'h00;
`ifdef SEG_LZ_BLANK_EN
        for (int i = 1; i < 8; i++) if (v[4*i +: 4] != 4'd0) msd = 3'(i);
        if (s > msd) return 8'h00;
`else
        msd = v[2:0];
`endif
        return 8'h01 << s;
    endfunction

    function automatic logic exp_fs(int c);
        return (c > 0) && (c % 40 == 0);
    endfunction

    function automatic logic [3:0] nib(logic [31:0] v, logic [2:0] s);
        return v[s*4 +: 4];
    endfunction

    task automatic wait_phase(int m);
        while (cyc % 40 != m) tick();
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!o_frame_start && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (o_frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", o_frame_start, n);
        end
    endtask

    // Checks digit and overlay ownership over nf whole frames starting now.
    task automatic check_frames(string name, int nf, logic [31:0] v0, logic [31:0] v1,
                                logic [31:0] v2, logic [31:0] v3, logic [3:0] ovl);
        logic [31:0] v;
        for (int f = 0; f < nf; f++) begin
            v = (f == 0) ? v0 : (f == 1) ? v1 : (f == 2) ? v2 : v3;
            for (int j = 0; j < 40; j++) begin
                checks++;
                if (o_digit !== nib(v, 3'(j / 5))) begin
                    errors++;
                    $display("FAIL %s digit f%0d j%0d: got %h, required %h", name, f, j, o_digit, nib(v, 3'(j / 5)));
                end
                checks++;
                if (o_overlay_active !== ovl[f]) begin
                    errors++;
                    $display("FAIL %s overlay f%0d j%0d: got %b, required %b", name, f, j, o_overlay_active, ovl[f]);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        cyc = 0;
        checks++;
        if (o_digit_sel !== 3'd0 || o_seg_en !== 8'h01 || o_digit !== 4'h0) begin
            errors++;
            $display("FAIL reset_scan: sel=%0d seg=%h digit=%h, required 0 01 0", o_digit_sel, o_seg_en, o_digit);
        end
        checks++;
        if (o_dbg_ack !== 1'b0 || o_frame_start !== 1'b0 || o_overlay_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ack=%b fs=%b ovl=%b, required 0 0 0", o_dbg_ack, o_frame_start, o_overlay_active);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        for (int k = 0; k <= 80; k++) begin
            checks++;
            if (o_seg_en !== exp_seg(cyc, 32'h0) || o_digit_sel !== exp_sel(cyc) || o_frame_start !== exp_fs(cyc)) begin
                errors++;
                $display("FAIL scan cyc%0d: seg=%h sel=%0d fs=%b, required %h %0d %b", cyc, o_seg_en, o_digit_sel,
                         o_frame_start, exp_seg(cyc, 32'h0), exp_sel(cyc), exp_fs(cyc));
            end
            tick();
        end
    endtask

    task automatic test_cpu_write();
        wait_phase(10);
        i_cpu_wr_en   = 1'b1;
        i_cpu_wr_data = 32'h1234ABCD;
        tick();
        i_cpu_wr_en   = 1'b0;
        checks++;
        if (o_digit !== 4'h0) begin
            errors++;
            $display("FAIL cpu_no_tear: digit=%h mid-frame, required 0", o_digit);
        end
        wait_frame();
        check_frames("cpu_write", 1, 32'h1234ABCD, 32'h0, 32'h0, 32'h0, 4'b0000);
    endtask

    task automatic test_overlay();
        wait_phase(15);
        i_dbg_req  = 1'b1;
        i_dbg_data = 32'hDEADBEEF;
        tick();
        checks++;
        if (o_dbg_ack !== 1'b1 || o_overlay_active !== 1'b1) begin
            errors++;
            $display("FAIL ovl_ack: ack=%b ovl=%b, required 1 1", o_dbg_ack, o_overlay_active);
        end
        i_dbg_req = 1'b0;
        tick();
        checks++;
        if (o_dbg_ack !== 1'b0 || o_digit !== nib(32'h1234ABCD, exp_sel(cyc))) begin
            errors++;
            $display("FAIL ovl_after_ack: ack=%b digit=%h, required 0 %h", o_dbg_ack, o_digit,
                     nib(32'h1234ABCD, exp_sel(cyc)));
        end
        wait_frame();
        check_frames("overlay", 3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1234ABCD, 32'h0, 4'b0011);
    endtask

    task automatic test_collision();
        wait_phase(39);
        i_cpu_wr_en   = 1'b1;
        i_cpu_wr_data = 32'h00C0FFEE;
        i_dbg_req     = 1'b1;
        i_dbg_data    = 32'h55AA1234;
        tick();
        i_cpu_wr_en   = 1'b0;
        i_dbg_req     = 1'b0;
        checks++;
        if (o_frame_start !== 1'b1 || o_dbg_ack !== 1'b1 || o_overlay_active !== 1'b1) begin
            errors++;
            $display("FAIL coll_edge: fs=%b ack=%b ovl=%b, required 1 1 1", o_frame_start, o_dbg_ack, o_overlay_active);
        end
        check_frames("collision", 4, 32'h1234ABCD, 32'h55AA1234, 32'h55AA1234, 32'h00C0FFEE, 4'b0111);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack = 4'b0101;
        i_dbg_req  = 1'b1;
        i_dbg_data = 32'h00000777;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) i_dbg_req = 1'b0;
            checks++;
            if (o_dbg_ack !== exp_ack[i] || o_overlay_active !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ack%0d: ack=%b ovl=%b, required %b 1", i, o_dbg_ack, o_overlay_active, exp_ack[i]);
            end
        end
        tick();
        checks++;
        if (o_dbg_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: ack=%b, required 0", o_dbg_ack);
        end
    endtask

    task automatic test_mid_reset();
        wait_phase(29);
        checks++;
        if (o_digit_sel !== 3'd5 || o_seg_en !== 8'h00) begin
            errors++;
            $display("FAIL pre_reset_blank5: sel=%0d seg=%h, required 5 00", o_digit_sel, o_seg_en);
        end
        rst       = 1'b1;
        i_dbg_req = 1'b1;
        tick();
        cyc = 0;
        checks++;
        if (o_digit_sel !== 3'd0 || o_seg_en !== 8'h01 || o_digit !== 4'h0 || o_dbg_ack !== 1'b0 ||
            o_overlay_active !== 1'b0 || o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sel=%0d seg=%h digit=%h ack=%b ovl=%b fs=%b, required 0 01 0 0 0 0",
                     o_digit_sel, o_seg_en, o_digit, o_dbg_ack, o_overlay_active, o_frame_start);
        end
        rst       = 1'b0;
        i_dbg_req = 1'b0;
        for (int k = 0; k <= 44; k++) begin
            checks++;
            if (o_seg_en !== exp_seg(cyc, 32'h0) || o_digit !== 4'h0) begin
                errors++;
                $display("FAIL post_reset cyc%0d: seg=%h digit=%h, required %h 0", cyc, o_seg_en, o_digit,
                         exp_seg(cyc, 32'h0));
            end
            tick();
        end
    endtask

`ifdef SEG_LZ_BLANK_EN
    task automatic test_lz();
        logic [31:0] vals [2];
        vals[0] = 32'h00000A05;
        vals[1] = 32'h00000000;
        for (int t = 0; t < 2; t++) begin
            wait_phase(10);
            i_cpu_wr_en   = 1'b1;
            i_cpu_wr_data = vals[t];
            tick();
            i_cpu_wr_en   = 1'b0;
            wait_frame();
            for (int j = 0; j < 40; j++) begin
                checks++;
                if (o_seg_en !== exp_seg(cyc, vals[t]) || o_digit_sel !== exp_sel(cyc)) begin
                    errors++;
                    $display("FAIL lz v%0d j%0d: seg=%h sel=%0d, required %h %0d", t, j, o_seg_en, o_digit_sel,
                             exp_seg(cyc, vals[t]), exp_sel(cyc));
                end
                tick();
            end
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        i_cpu_wr_en   = 1'b0;
        i_cpu_wr_data = 32'h0;
        i_dbg_req     = 1'b0;
        i_dbg_data    = 32'h0;
        test_reset();
        test_scan();
        test_cpu_write();
        test_overlay();
        test_collision();
        test_back_to_back();
        test_mid_reset();
`ifdef SEG_LZ_BLANK_EN
        test_lz();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
